// File: rtl/input_cmd_queue.sv
// Tetris input command queue: per-button auto-repeat FSMs feeding a small
// command FIFO that the game-logic FSM drains over a valid/ready handshake.
module input_cmd_queue #(
    parameter int unsigned DELAY_TICKS  = 6250000,
    parameter int unsigned REPEAT_TICKS = 2500000,
    parameter logic [3:0]  REPEAT_MASK  = 4'b1011,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] press,
    input  logic [3:0] release_pulse,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    input  logic       cmd_ready,
    output logic       overflow
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_REPEAT = 2'd3;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [23:0] DELAY_LAST = 24'(DELAY_TICKS - 1);
    localparam logic [23:0] REPEAT_LAST = 24'(REPEAT_TICKS - 1);

    logic [1:0]  state_q [4];
    logic [1:0]  state_d [4];
    logic [23:0] cnt_q [4];
    logic [23:0] cnt_d [4];
    logic [3:0]  ev;
    logic [3:0]  pending;
    logic [3:0]  grant;
    logic [1:0]  push_code;
    logic        push;
    logic        pop;
    logic        full;

    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    // Release wins over a terminal count landing on the same edge.
    always_comb begin
        ev = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                ST_IDLE: begin
                    if (press[i]) begin
                        ev[i]    = 1'b1;
                        cnt_d[i] = '0;
                        if (!release_pulse[i])
                            state_d[i] = REPEAT_MASK[i] ? ST_WAIT : ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (release_pulse[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                end
                ST_WAIT: begin
                    if (release_pulse[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DELAY_LAST) begin
                        ev[i]      = 1'b1;
                        cnt_d[i]   = '0;
                        state_d[i] = ST_REPEAT;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 24'd1;
                    end
                end
                ST_REPEAT: begin
                    if (release_pulse[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == REPEAT_LAST) begin
                        ev[i]    = 1'b1;
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 24'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign full = (count_q == FULL_COUNT);
    assign pop  = cmd_valid && cmd_ready;

    always_comb begin
        grant     = '0;
        push_code = 2'd0;
        if (!full) begin
            priority case (1'b1)
                pending[0]: begin grant = 4'b0001; push_code = 2'd0; end
                pending[1]: begin grant = 4'b0010; push_code = 2'd1; end
                pending[2]: begin grant = 4'b0100; push_code = 2'd2; end
                pending[3]: begin grant = 4'b1000; push_code = 2'd3; end
                default: ;
            endcase
        end
    end

    assign push = |grant;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pending  <= (pending & ~grant) | ev;
            overflow <= |(ev & pending & ~grant);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            cmd_valid <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_code;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count_q   <= count_d;
            cmd_valid <= (count_d != '0);
        end
    end

    assign cmd_code = mem[rd_ptr];

endmodule

// File: tb/tb_input_cmd_queue.sv
// Scoreboard bench for input_cmd_queue with short repeat timing.
module tb_input_cmd_queue;

    localparam int D = 8;
    localparam int R = 4;
    localparam logic [3:0] MASK = 4'b1011;

    typedef struct {
        int code;
        int at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_ready;
    logic       overflow;

    int   checks = 0;
    int   fails = 0;
    int   ecount = 0;
    int   ovf_cnt = 0;
    int   pop_cnt = 0;
    exp_t exp_q[$];

    input_cmd_queue #(
        .DELAY_TICKS (D),
        .REPEAT_TICKS(R),
        .REPEAT_MASK (MASK),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .press        (press),
        .release_pulse(release_pulse),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .cmd_ready    (cmd_ready),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecount <= ecount + 1;

    always @(negedge clk) begin
        if (!rst && overflow)
            ovf_cnt++;
        if (!rst && cmd_valid && cmd_ready) begin
            exp_t e;
            pop_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL cmd_scoreboard: got code %0d at edge %0d, required no command",
                         cmd_code, ecount);
            end else begin
                e = exp_q.pop_front();
                if (cmd_code !== 2'(e.code) || (e.at >= 0 && ecount != e.at)) begin
                    fails++;
                    $display("FAIL cmd_scoreboard: got code %0d at edge %0d, required code %0d at edge %0d",
                             cmd_code, ecount, e.code, e.at);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_cmd(input int code, input int at);
        exp_q.push_back('{code, at});
    endtask

    // Press edge p gives valid after edge p+1; repeats at p+D, p+D+k*R before release.
    task automatic expect_hold(input int b, input int hold, input int p);
        expect_cmd(b, p + 1);
        if (MASK[b])
            for (int t = p + D; t < p + hold; t += R)
                expect_cmd(b, t + 1);
    endtask

    task automatic tap(input int b, input int hold);
        press[b] = 1'b1;
        cycles(1);
        press[b] = 1'b0;
        cycles(hold - 1);
        release_pulse[b] = 1'b1;
        cycles(1);
        release_pulse[b] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        press = '0;
        release_pulse = '0;
        cmd_ready = 1'b0;
        cycles(3);
        checks += 3;
        if (cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b, required 0", cmd_valid);
        end
        if (cmd_code !== 2'd0) begin
            fails++;
            $display("FAIL reset_code: got %0d, required 0", cmd_code);
        end
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_overflow: got %b, required 0", overflow);
        end
        rst = 1'b0;
        cycles(2);
    endtask

    task automatic test_single_tap;
        int p;
        cmd_ready = 1'b1;
        p = ecount + 1;
        expect_hold(0, 2, p);
        tap(0, 2);
        cycles(30);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL single_tap_drained: got %0d missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_auto_repeat;
        int p;
        int holds[3] = '{30, 8, 9};
        int btns[3] = '{1, 3, 3};
        cmd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            p = ecount + 1;
            expect_hold(btns[k], holds[k], p);
            tap(btns[k], holds[k]);
            cycles(20);
            checks++;
            if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL auto_repeat_hold%0d: got %0d missing, required 0",
                         holds[k], exp_q.size());
            end
        end
    endtask

    task automatic test_no_repeat_rotate;
        int p;
        cmd_ready = 1'b1;
        p = ecount + 1;
        expect_hold(2, 100, p);
        tap(2, 100);
        cycles(10);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rotate_drained: got %0d missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_simultaneous;
        int p;
        int o;
        cmd_ready = 1'b1;
        o = ovf_cnt;
        p = ecount + 1;
        expect_cmd(0, p + 1);
        expect_cmd(3, p + 2);
        press = 4'b1001;
        cycles(1);
        press = '0;
        cycles(2);
        release_pulse = 4'b1001;
        cycles(1);
        release_pulse = '0;
        cycles(10);
        checks += 2;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL simultaneous_drained: got %0d missing, required 0", exp_q.size());
        end
        if (ovf_cnt != o) begin
            fails++;
            $display("FAIL simultaneous_overflow: got %0d pulses, required 0", ovf_cnt - o);
        end
    endtask

    task automatic test_full_overflow;
        int o;
        cmd_ready = 1'b0;
        o = ovf_cnt;
        for (int k = 0; k < 5; k++) begin
            expect_cmd(0, -1);
            tap(0, 2);
            cycles(18);
        end
        checks += 3;
        if (cmd_valid !== 1'b1) begin
            fails++;
            $display("FAIL full_valid: got %b, required 1", cmd_valid);
        end
        if (cmd_code !== 2'd0) begin
            fails++;
            $display("FAIL full_code: got %0d, required 0", cmd_code);
        end
        if (ovf_cnt != o) begin
            fails++;
            $display("FAIL full_no_overflow_yet: got %0d pulses, required 0", ovf_cnt - o);
        end
        tap(0, 2);
        cycles(5);
        checks++;
        if (ovf_cnt != o + 1) begin
            fails++;
            $display("FAIL sixth_tap_overflow: got %0d pulses, required 1", ovf_cnt - o);
        end
        cmd_ready = 1'b1;
        cycles(12);
        checks += 2;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL full_drained: got %0d missing, required 0", exp_q.size());
        end
        if (cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_empty_after: got valid %b, required 0", cmd_valid);
        end
    endtask

    task automatic test_reset_mid_hold;
        int p;
        int pops;
        cmd_ready = 1'b0;
        press[3] = 1'b1;
        cycles(1);
        press[3] = 1'b0;
        cycles(9);
        checks++;
        if (cmd_valid !== 1'b1) begin
            fails++;
            $display("FAIL hold_valid_before_reset: got %b, required 1", cmd_valid);
        end
        rst = 1'b1;
        #1;
        checks += 2;
        if (cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_async_valid: got %b, required 0", cmd_valid);
        end
        if (cmd_code !== 2'd0) begin
            fails++;
            $display("FAIL reset_async_code: got %0d, required 0", cmd_code);
        end
        exp_q.delete();
        cycles(3);
        rst = 1'b0;
        cmd_ready = 1'b1;
        pops = pop_cnt;
        cycles(40);
        release_pulse[3] = 1'b1;
        cycles(1);
        release_pulse[3] = 1'b0;
        cycles(5);
        checks++;
        if (pop_cnt != pops) begin
            fails++;
            $display("FAIL held_after_reset: got %0d commands, required 0", pop_cnt - pops);
        end
        p = ecount + 1;
        expect_hold(3, 4, p);
        tap(3, 4);
        cycles(10);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL repress_after_reset: got %0d missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_tap();
        test_auto_repeat();
        test_no_repeat_rotate();
        test_simultaneous();
        test_full_overflow();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
